// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time, IDLE -> REQ -> WAIT -> RESP.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module lsu #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the valid side holds its payload stable until then and never waits on ready.

  localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          bad_acc;
  logic [1:0]    off;
  logic [31:0]   shifted;
  logic [31:0]   ld_ext;
  logic          timeout;

  // Illegal size always errors; misalignment errors only in the trapping build.
  always_comb begin
    bad_acc = (in_funct3[1:0] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (in_funct3[1:0] == 2'b01 && in_addr[0]) bad_acc = 1'b1;
    if (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00) bad_acc = 1'b1;
`endif
  end

  // Byte offset within the word; half and word accesses are forced onto their natural boundary.
  always_comb begin
    case (f3_q[1:0])
      2'b01:   off = {addr_q[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr_q[1:0];
    endcase
  end

  always_comb begin
    mem_wmask = 4'b1111;
    mem_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        mem_wdata = {4{wdata_q[7:0]}};
        if (we_q) mem_wmask = 4'b0001 << off;
      end
      2'b01: begin
        mem_wdata = {2{wdata_q[15:0]}};
        if (we_q) mem_wmask = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{shifted[7] & ~f3_q[2]}}, shifted[7:0]};
      2'b01:   ld_ext = {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign timeout       = (WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == RESP);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_we        = we_q;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          we_d    = in_we;
          f3_d    = in_funct3;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          rdata_d = 32'h0;
          err_d   = bad_acc;
          state_d = bad_acc ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the timeout cycle still counts as success.
        if (mem_rsp_valid) begin
          rdata_d = we_q ? 32'h0 : ld_ext;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed corner cases plus randomized operations against a behavioural model.
// The driver keeps the expected interface picture current; a negedge process compares every cycle.
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_we;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [1:0]  dbg_state;

  lsu #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int exp_hs = 0;

  logic        exp_in_ready, exp_req, exp_out, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_mask;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b10) return 0;
    if (f3[1:0] == 2'b01) return (a[1] ? 2 : 0);
    return int'(a[1:0]);
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_mask(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int lanes;
    if (!we) return 4'b1111;
    lanes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return 4'(((1 << lanes) - 1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return wd[7:0] * 32'h01010101;
    if (f3[1:0] == 2'b01) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * m_off(f3, a));
    if (f3[1:0] == 2'b00) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'b01) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("in_ready", {32'h0, in_ready}, {32'h0, exp_in_ready});
    chk("mem_req_valid", {32'h0, mem_req_valid}, {32'h0, exp_req});
    chk("out_valid", {32'h0, out_valid}, {32'h0, exp_out});
    if (exp_req) begin
      chk("mem_addr", {1'b0, mem_addr}, {1'b0, exp_addr});
      chk("mem_we", {32'h0, mem_we}, {32'h0, exp_we});
      chk("mem_wmask", {29'h0, mem_wmask}, {29'h0, exp_mask});
      if (exp_we) chk("mem_wdata", {1'b0, mem_wdata}, {1'b0, exp_wdata});
    end
    if (exp_out) begin
      chk("out_rdata", {1'b0, out_rdata}, {1'b0, exp_rdata});
      chk("out_err", {32'h0, out_err}, {32'h0, exp_err});
    end
  end

  // Scoreboard: every result handshake consumes one expected {err, rdata}.
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) hs_count++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_result", 33'h1, 33'h0);
      else chk("sb_result", {out_err, out_rdata}, exp_q.pop_front());
    end
  end

  task automatic go_idle_expect();
    exp_in_ready = 1'b1;
    exp_req = 1'b0;
    exp_out = 1'b0;
  endtask

  // abort: 0 none, 1 reset during REQ stall, 2 reset during WAIT
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int stall, input int dly, input int ostall, input int abort);
    logic [32:0] res;
    bit trap;
    trap = m_trap(f3, a);
    in_valid = 1'b1; in_we = we; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = $urandom(); in_wdata = $urandom(); in_funct3 = 3'($urandom());
    exp_in_ready = 1'b0;
    res = {1'b1, 32'h0};
    if (!trap) begin
      exp_req = 1'b1; exp_we = we; exp_addr = {a[31:2], 2'b00};
      exp_mask = m_mask(we, f3, a); exp_wdata = m_wdata(f3, wd);
      mem_req_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (abort == 1 && i == 1) begin
          rst = 1'b1;
          #1;
          chk("async_req_drop", {32'h0, mem_req_valid}, 33'h0);
          go_idle_expect();
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; exp_req = 1'b0; exp_hs++;
      for (int k = 1; k <= TO; k++) begin
        if (abort == 2 && k == 3) begin
          rst = 1'b1;
          go_idle_expect();
          @(posedge clk); #1;
          rst = 1'b0;
          mem_rsp_valid = 1'b1; mem_rdata = $urandom();
          repeat (2) begin @(posedge clk); #1; end
          mem_rsp_valid = 1'b0;
          return;
        end
        if (k == dly) begin mem_rsp_valid = 1'b1; mem_rdata = rd; end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rdata = $urandom();
        if (k == dly) begin
          res = {1'b0, (we ? 32'h0 : m_load(f3, a, rd))};
          break;
        end
      end
    end
    exp_q.push_back(res);
    exp_out = 1'b1; exp_rdata = res[31:0]; exp_err = res[32];
    for (int i = 0; i < ostall; i++) begin @(posedge clk); #1; end
    // A new request offered in the release cycle must not be taken in that same cycle.
    out_ready = 1'b1; in_valid = 1'b1; in_we = 1'($urandom());
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    go_idle_expect();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'b000; in_addr = 32'h0; in_wdata = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;
    exp_we = 1'b0; exp_err = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0; exp_mask = 4'h0;
    go_idle_expect();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-computed values that pin the model.
    chk("pin_lb", {1'b0, m_load(3'b000, 32'h80000003, 32'h80FF7F01)}, {1'b0, 32'hFFFFFF80});
    chk("pin_lbu", {1'b0, m_load(3'b100, 32'h80000003, 32'h80FF7F01)}, {1'b0, 32'h00000080});
    chk("pin_sh_mask", {29'h0, m_mask(1'b1, 3'b001, 32'h102)}, {29'h0, 4'b1100});
    chk("pin_sh_wdata", {1'b0, m_wdata(3'b001, 32'h1234ABCD)}, {1'b0, 32'hABCDABCD});
    chk("pin_sw_mask", {29'h0, m_mask(1'b1, 3'b010, 32'h80000004)}, {29'h0, 4'b1111});
    chk("pin_lh_neg", {1'b0, m_load(3'b001, 32'h2, 32'h80017FFF)}, {1'b0, 32'hFFFF8001});

    // Directed corner cases.
    do_op(1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0, 0, 1, 0, 0);
    do_op(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF7F01, 0, 1, 0, 0);
    do_op(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF7F01, 1, 2, 1, 0);
    do_op(1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 32'h0, 3, 1, 0, 0);
    do_op(1'b0, 3'b010, 32'h00000100, 32'h0, 32'h0, 0, 99, 0, 0);
    do_op(1'b0, 3'b010, 32'h00000104, 32'h0, 32'h13579BDF, 0, 2, 0, 0);
    do_op(1'b0, 3'b010, 32'h00000104, 32'h0, 32'h2468ACE0, 0, TO, 0, 0);
    do_op(1'b0, 3'b010, 32'h00000002, 32'h0, 32'hCAFEF00D, 0, 1, 0, 0);
    do_op(1'b0, 3'b011, 32'h00000010, 32'h0, 32'h0, 0, 1, 2, 0);
    do_op(1'b0, 3'b101, 32'h00000013, 32'h0, 32'hF00DBEEF, 0, 1, 0, 0);
    do_op(1'b0, 3'b010, 32'h00000200, 32'h0, 32'h0, 0, 99, 0, 2);
    do_op(1'b0, 3'b010, 32'h00000204, 32'h0, 32'h55AA55AA, 0, 1, 0, 0);
    do_op(1'b1, 3'b000, 32'h00000301, 32'h000000A5, 32'h0, 4, 1, 0, 1);
    do_op(1'b1, 3'b000, 32'h00000301, 32'h000000A5, 32'h0, 0, 1, 0, 0);

    // Randomized operations.
    for (int n = 0; n < 300; n++) begin
      int dly;
      dly = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(1, TO);
      do_op(1'($urandom()), 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
            $urandom_range(0, 3), dly, $urandom_range(0, 2), 0);
    end

    @(posedge clk); #1;
    chk("handshake_count", 33'(hs_count), 33'(exp_hs));
    chk("scoreboard_drained", 33'(exp_q.size()), 33'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
